// File: rtl/uart_tx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_if
// Producer-side and line-side signals of the queued UART transmitter.
//   tx_data    : word to queue (DATA_BITS wide)
//   tx_valid   : producer has a word on tx_data
//   tx_ready   : FIFO can accept a word (not full)
//   tx_port    : serial line, idles high
//   tx_busy    : a frame is on the line or the FIFO holds words
//   fifo_level : current FIFO occupancy
// master = producer / observer side, slave = transmitter side.
// ---------------------------------------------------------------------------
interface uart_tx_fifo_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4
);
   logic [DATA_BITS-1:0]          tx_data;
   logic                          tx_valid;
   logic                          tx_ready;
   logic                          tx_port;
   logic                          tx_busy;
   logic [$clog2(FIFO_DEPTH):0]   fifo_level;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, tx_port, tx_busy, fifo_level
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, tx_port, tx_busy, fifo_level
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// UART transmitter with configurable word length, parity, stop bits and baud
// divisor, fed by a small circular FIFO. Frames are sent back-to-back with
// every bit exactly CLK_DIV cycles long.
// Ports:
//   sys_clk   : system clock, rising edge
//   sys_rst_n : asynchronous active-low reset
//   bus       : uart_tx_fifo_if.slave (tx_data/tx_valid/tx_ready handshake,
//               tx_port line, tx_busy, fifo_level)
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int CLK_DIV    = 10416,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic            sys_clk,
   input  logic            sys_rst_n,
   uart_tx_fifo_if.slave   bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [15:0]      RELOAD   = 16'(CLK_DIV - 1);
   localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);
   localparam logic             LAST_STP = 1'(STOP_BITS - 1);
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

   // Elaboration-time rejection of illegal parameter values.
   if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
      $error("uart_tx_fifo: CLK_DIV out of range 2..65535");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_fifo: DATA_BITS out of range 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two in 2..64");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t                 state_q, state_d;
   logic [15:0]            timer_q, timer_d;
   logic [3:0]             bit_cnt_q, bit_cnt_d;
   logic                   stop_cnt_q, stop_cnt_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   par_q, par_d;
   logic                   tx_q, tx_d;
   logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]       level_q, level_d;
   logic                   ready_q;
   logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];

   logic push;
   logic pop;
   logic bit_end;
   logic not_empty;

   // ready_q is only ever 0 when full, so a full FIFO never takes a write,
   // even on an edge where a pop frees a slot.
   assign push      = bus.tx_valid && ready_q;
   assign bit_end   = (timer_q == '0);
   assign not_empty = (level_q != '0);

   always_comb begin
      state_d    = state_q;
      timer_d    = bit_end ? '0 : timer_q - 1'b1;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      tx_d       = tx_q;
      pop        = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            pop = not_empty;
         end
         S_START: begin
            if (bit_end) begin
               tx_d      = shift_q[0];
               shift_d   = shift_q >> 1;
               par_d     = shift_q[0];
               bit_cnt_d = '0;
               timer_d   = RELOAD;
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               timer_d = RELOAD;
               if (bit_cnt_q == LAST_BIT) begin
                  if (PARITY != 0) begin
                     // par_q holds the XOR of all data bits here.
                     tx_d    = (PARITY == 2) ? par_q : ~par_q;
                     state_d = S_PARITY;
                  end else begin
                     tx_d       = 1'b1;
                     stop_cnt_d = 1'b0;
                     state_d    = S_STOP;
                  end
               end else begin
                  tx_d      = shift_q[0];
                  shift_d   = shift_q >> 1;
                  par_d     = par_q ^ shift_q[0];
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               tx_d       = 1'b1;
               stop_cnt_d = 1'b0;
               timer_d    = RELOAD;
               state_d    = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               timer_d = RELOAD;
               if (stop_cnt_q == LAST_STP) begin
                  // Zero idle gap: the next start bit begins on this edge.
                  if (not_empty) pop = 1'b1;
                  else           state_d = S_IDLE;
               end else begin
                  stop_cnt_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (pop) begin
         shift_d = mem[rd_ptr_q];
         tx_d    = 1'b0;
         timer_d = RELOAD;
         state_d = S_START;
      end
   end

   always_comb begin
      level_d = level_q;
      unique case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= S_IDLE;
         timer_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         tx_q       <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         ready_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         tx_q       <= tx_d;
         level_q    <= level_d;
         ready_q    <= (level_d != FULL_LVL);
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage carries no reset; stale entries are never read because the
   // level counter gates every pop.
   always_ff @(posedge sys_clk) begin
      if (push) mem[wr_ptr_q] <= bus.tx_data;
   end

   assign bus.tx_ready   = ready_q;
   assign bus.tx_port    = tx_q;
   assign bus.tx_busy    = (state_q != S_IDLE) || not_empty;
   assign bus.fifo_level = level_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
// Directed self-checking bench. Three transmitter instances cover the
// parameter sets needed: A (CLK_DIV=4, 8N1, depth 4), B (CLK_DIV=3, 7 bits,
// even parity, 2 stop) and C (CLK_DIV=3, 8 bits, odd parity, 1 stop).
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;
   logic sys_clk   = 1'b0;
   logic sys_rst_n = 1'b1;
   always #5 sys_clk = ~sys_clk;

   uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus_a ();
   uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) bus_b ();
   uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus_c ();

   uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
      dut_a (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus_a.slave));
   uart_tx_fifo #(.CLK_DIV(3), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4))
      dut_b (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus_b.slave));
   uart_tx_fifo #(.CLK_DIV(3), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
      dut_c (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus_c.slave));

   int   checks   = 0;
   int   failures = 0;
   logic cap      [0:511];
   logic exp_bits [0:127];
   int   exp_len;

   // Append the expected line levels of one frame (one entry per bit).
   task automatic add_frame(input int data, input int nbits, input int par, input int nstop);
      int ones;
      ones = 0;
      exp_bits[exp_len] = 1'b0;
      exp_len++;
      for (int b = 0; b < nbits; b++) begin
         exp_bits[exp_len] = data[b];
         if (data[b]) ones++;
         exp_len++;
      end
      if (par != 0) begin
         exp_bits[exp_len] = (par == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
         exp_len++;
      end
      for (int s = 0; s < nstop; s++) begin
         exp_bits[exp_len] = 1'b1;
         exp_len++;
      end
   endtask

   // Record n line samples, one per falling edge, starting at cap[start].
   task automatic capture(input int sel, input int start, input int n);
      for (int i = start; i < start + n; i++) begin
         @(negedge sys_clk);
         case (sel)
            0:       cap[i] = bus_a.tx_port;
            1:       cap[i] = bus_b.tx_port;
            default: cap[i] = bus_c.tx_port;
         endcase
      end
   endtask

   task automatic test_reset;
      bus_a.tx_valid = 1'b0; bus_a.tx_data = '0;
      bus_b.tx_valid = 1'b0; bus_b.tx_data = '0;
      bus_c.tx_valid = 1'b0; bus_c.tx_data = '0;
      #1 sys_rst_n = 1'b0;
      #12;
      checks++; if (bus_a.tx_port !== 1'b1) begin failures++; $display("FAIL rst_a_port got=%b want=1", bus_a.tx_port); end
      checks++; if (bus_a.tx_ready !== 1'b1) begin failures++; $display("FAIL rst_a_ready got=%b want=1", bus_a.tx_ready); end
      checks++; if (bus_a.tx_busy !== 1'b0) begin failures++; $display("FAIL rst_a_busy got=%b want=0", bus_a.tx_busy); end
      checks++; if (bus_a.fifo_level !== 3'd0) begin failures++; $display("FAIL rst_a_level got=%0d want=0", bus_a.fifo_level); end
      checks++; if (bus_b.tx_port !== 1'b1) begin failures++; $display("FAIL rst_b_port got=%b want=1", bus_b.tx_port); end
      checks++; if (bus_b.tx_ready !== 1'b1) begin failures++; $display("FAIL rst_b_ready got=%b want=1", bus_b.tx_ready); end
      checks++; if (bus_c.tx_busy !== 1'b0) begin failures++; $display("FAIL rst_c_busy got=%b want=0", bus_c.tx_busy); end
      checks++; if (bus_c.fifo_level !== 3'd0) begin failures++; $display("FAIL rst_c_level got=%0d want=0", bus_c.fifo_level); end
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
      $display("test_reset done");
   endtask

   // 0xA5, CLK_DIV=4, 8N1: line 0,1,0,1,0,0,1,0,1,1 for 4 cycles each.
   task automatic test_basic_frame;
      bus_a.tx_data  = 8'hA5;
      bus_a.tx_valid = 1'b1;
      @(negedge sys_clk);
      bus_a.tx_valid = 1'b0;
      checks++; if (bus_a.tx_port !== 1'b1) begin failures++; $display("FAIL t1_no_fall_on_write got=%b want=1", bus_a.tx_port); end
      checks++; if (bus_a.fifo_level !== 3'd1) begin failures++; $display("FAIL t1_level got=%0d want=1", bus_a.fifo_level); end
      checks++; if (bus_a.tx_busy !== 1'b1) begin failures++; $display("FAIL t1_busy got=%b want=1", bus_a.tx_busy); end
      exp_len = 0;
      add_frame(32'hA5, 8, 0, 1);
      capture(0, 0, exp_len * 4);
      for (int i = 0; i < exp_len * 4; i++) begin
         checks++;
         if (cap[i] !== exp_bits[i / 4]) begin
            failures++;
            $display("FAIL t1_line sample=%0d got=%b want=%b", i, cap[i], exp_bits[i / 4]);
         end
      end
      @(negedge sys_clk);
      checks++; if (bus_a.tx_busy !== 1'b0) begin failures++; $display("FAIL t1_busy_end got=%b want=0", bus_a.tx_busy); end
      checks++; if (bus_a.tx_port !== 1'b1) begin failures++; $display("FAIL t1_idle_line got=%b want=1", bus_a.tx_port); end
      $display("test_basic_frame done: 0xA5 %0d samples", exp_len * 4);
   endtask

   // 7 bits, even parity, 2 stop, CLK_DIV=3, 0x53: 33-cycle frame.
   task automatic test_parity_even;
      bus_b.tx_data  = 7'h53;
      bus_b.tx_valid = 1'b1;
      @(negedge sys_clk);
      bus_b.tx_valid = 1'b0;
      checks++; if (bus_b.tx_port !== 1'b1) begin failures++; $display("FAIL t2_no_fall_on_write got=%b want=1", bus_b.tx_port); end
      exp_len = 0;
      add_frame(32'h53, 7, 2, 2);
      capture(1, 0, exp_len * 3);
      for (int i = 0; i < exp_len * 3; i++) begin
         checks++;
         if (cap[i] !== exp_bits[i / 3]) begin
            failures++;
            $display("FAIL t2_line sample=%0d got=%b want=%b", i, cap[i], exp_bits[i / 3]);
         end
      end
      @(negedge sys_clk);
      checks++; if (bus_b.tx_busy !== 1'b0) begin failures++; $display("FAIL t2_busy_end got=%b want=0", bus_b.tx_busy); end
      $display("test_parity_even done: 0x53 %0d samples", exp_len * 3);
   endtask

   // Odd parity, 0x00 then 0xFF back-to-back: both parity bits are 1.
   task automatic test_parity_odd;
      bus_c.tx_data  = 8'h00;
      bus_c.tx_valid = 1'b1;
      @(negedge sys_clk);
      checks++; if (bus_c.tx_port !== 1'b1) begin failures++; $display("FAIL t3_no_fall_on_write got=%b want=1", bus_c.tx_port); end
      bus_c.tx_data = 8'hFF;
      @(negedge sys_clk);
      bus_c.tx_valid = 1'b0;
      // This sample is already the first cycle of the 0x00 frame.
      cap[0] = bus_c.tx_port;
      exp_len = 0;
      add_frame(32'h00, 8, 1, 1);
      add_frame(32'hFF, 8, 1, 1);
      capture(2, 1, exp_len * 3 - 1);
      for (int i = 0; i < exp_len * 3; i++) begin
         checks++;
         if (cap[i] !== exp_bits[i / 3]) begin
            failures++;
            $display("FAIL t3_line sample=%0d got=%b want=%b", i, cap[i], exp_bits[i / 3]);
         end
      end
      @(negedge sys_clk);
      checks++; if (bus_c.tx_busy !== 1'b0) begin failures++; $display("FAIL t3_busy_end got=%b want=0", bus_c.tx_busy); end
      $display("test_parity_odd done: 0x00,0xFF %0d samples", exp_len * 3);
   endtask

   // Words 1..6 with tx_valid held: fill to 4, stall, back-to-back frames.
   task automatic test_back_to_back;
      int n;
      int found;
      int max_level;
      exp_len = 0;
      for (int k = 1; k <= 6; k++) add_frame(k, 8, 0, 1);
      found     = 0;
      max_level = 0;
      fork
         begin
            for (int k = 1; k <= 6; k++) begin
               bus_a.tx_data  = 8'(k);
               bus_a.tx_valid = 1'b1;
               n = 0;
               while (!bus_a.tx_ready && n < 200) begin
                  @(negedge sys_clk);
                  n++;
               end
               checks++;
               if (n >= 200) begin failures++; $display("FAIL t4_accept_timeout word=%0d got=stalled want=accepted", k); end
               @(negedge sys_clk);
               if (k == 5) begin
                  checks++; if (bus_a.tx_ready !== 1'b0) begin failures++; $display("FAIL t4_ready_full got=%b want=0", bus_a.tx_ready); end
                  checks++; if (bus_a.fifo_level !== 3'd4) begin failures++; $display("FAIL t4_level_full got=%0d want=4", bus_a.fifo_level); end
               end
            end
            bus_a.tx_valid = 1'b0;
         end
         begin
            for (int w = 0; w < 50 && found == 0; w++) begin
               @(negedge sys_clk);
               if (bus_a.tx_port === 1'b0) found = 1;
            end
            if (found == 1) begin
               cap[0] = 1'b0;
               for (int i = 1; i < exp_len * 4; i++) begin
                  @(negedge sys_clk);
                  cap[i] = bus_a.tx_port;
                  if (int'(bus_a.fifo_level) > max_level) max_level = int'(bus_a.fifo_level);
               end
            end
         end
      join
      checks++;
      if (found == 0) begin
         failures++;
         $display("FAIL t4_start_timeout got=no_start want=start_bit");
      end else begin
         for (int i = 0; i < exp_len * 4; i++) begin
            checks++;
            if (cap[i] !== exp_bits[i / 4]) begin
               failures++;
               $display("FAIL t4_line sample=%0d got=%b want=%b", i, cap[i], exp_bits[i / 4]);
            end
         end
      end
      checks++; if (max_level > 4) begin failures++; $display("FAIL t4_max_level got=%0d want<=4", max_level); end
      @(negedge sys_clk);
      checks++; if (bus_a.tx_busy !== 1'b0) begin failures++; $display("FAIL t4_busy_end got=%b want=0", bus_a.tx_busy); end
      $display("test_back_to_back done: words 1..6 max_level=%0d", max_level);
   endtask

   // Reset during the data bits of the 2nd of 3 queued frames.
   task automatic test_reset_mid_frame;
      int bad;
      bus_a.tx_valid = 1'b1;
      bus_a.tx_data = 8'h11; @(negedge sys_clk);
      bus_a.tx_data = 8'h22; @(negedge sys_clk);
      bus_a.tx_data = 8'h33; @(negedge sys_clk);
      bus_a.tx_valid = 1'b0;
      // Frame 2 (0x22) starts 40 cycles after frame 1; its bit 0 (=0) is on the line here.
      repeat (44) @(negedge sys_clk);
      checks++; if (bus_a.tx_port !== 1'b0) begin failures++; $display("FAIL t5_pre_line got=%b want=0", bus_a.tx_port); end
      checks++; if (bus_a.fifo_level !== 3'd1) begin failures++; $display("FAIL t5_pre_level got=%0d want=1", bus_a.fifo_level); end
      #2 sys_rst_n = 1'b0;
      #1;
      checks++; if (bus_a.tx_port !== 1'b1) begin failures++; $display("FAIL t5_async_port got=%b want=1", bus_a.tx_port); end
      checks++; if (bus_a.fifo_level !== 3'd0) begin failures++; $display("FAIL t5_async_level got=%0d want=0", bus_a.fifo_level); end
      checks++; if (bus_a.tx_ready !== 1'b1) begin failures++; $display("FAIL t5_async_ready got=%b want=1", bus_a.tx_ready); end
      checks++; if (bus_a.tx_busy !== 1'b0) begin failures++; $display("FAIL t5_async_busy got=%b want=0", bus_a.tx_busy); end
      @(negedge sys_clk);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge sys_clk);
         if (bus_a.tx_port !== 1'b1 || bus_a.tx_busy !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL t5_no_frames_after got=%0d_active_samples want=0", bad); end
      $display("test_reset_mid_frame done");
   endtask

   // Push/pop on one edge at level 2, then order across pointer wrap (10 words).
   task automatic test_wrap_order;
      int n;
      int found;
      logic [7:0] w [10];
      for (int j = 0; j < 10; j++) w[j] = 8'(8'hC1 + j * 8'h13);
      exp_len = 0;
      for (int j = 0; j < 10; j++) add_frame(int'(w[j]), 8, 0, 1);
      found = 0;
      fork
         begin
            bus_a.tx_valid = 1'b1;
            for (int j = 0; j < 3; j++) begin
               bus_a.tx_data = w[j];
               @(negedge sys_clk);
            end
            bus_a.tx_valid = 1'b0;
            // Frame w0 popped one edge after its write; next pop is 40 cycles later.
            repeat (38) @(negedge sys_clk);
            checks++; if (bus_a.fifo_level !== 3'd2) begin failures++; $display("FAIL t6_level_before got=%0d want=2", bus_a.fifo_level); end
            bus_a.tx_data  = w[3];
            bus_a.tx_valid = 1'b1;
            @(negedge sys_clk);
            checks++; if (bus_a.fifo_level !== 3'd2) begin failures++; $display("FAIL t6_level_push_pop got=%0d want=2", bus_a.fifo_level); end
            for (int j = 4; j < 10; j++) begin
               bus_a.tx_data = w[j];
               n = 0;
               while (!bus_a.tx_ready && n < 200) begin
                  @(negedge sys_clk);
                  n++;
               end
               checks++;
               if (n >= 200) begin failures++; $display("FAIL t6_accept_timeout word=%0d got=stalled want=accepted", j); end
               @(negedge sys_clk);
            end
            bus_a.tx_valid = 1'b0;
         end
         begin
            for (int t = 0; t < 50 && found == 0; t++) begin
               @(negedge sys_clk);
               if (bus_a.tx_port === 1'b0) found = 1;
            end
            if (found == 1) begin
               cap[0] = 1'b0;
               capture(0, 1, exp_len * 4 - 1);
            end
         end
      join
      checks++;
      if (found == 0) begin
         failures++;
         $display("FAIL t6_start_timeout got=no_start want=start_bit");
      end else begin
         for (int i = 0; i < exp_len * 4; i++) begin
            checks++;
            if (cap[i] !== exp_bits[i / 4]) begin
               failures++;
               $display("FAIL t6_line sample=%0d got=%b want=%b", i, cap[i], exp_bits[i / 4]);
            end
         end
      end
      @(negedge sys_clk);
      checks++; if (bus_a.tx_busy !== 1'b0) begin failures++; $display("FAIL t6_busy_end got=%b want=0", bus_a.tx_busy); end
      $display("test_wrap_order done: 10 words %0d samples", exp_len * 4);
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_parity_even();
      test_parity_odd();
      test_back_to_back();
      test_reset_mid_frame();
      test_wrap_order();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "simulation time limit reached");
   end
endmodule
